// File: rtl/aes64_ks128_seq.sv
// AES-128 key-schedule sequencer: drives one aes64 unit through ks1/ks2/imix,
// one op per cycle, and streams round keys 0..10 over a valid/ready port.

package aes64_pkg;
    typedef struct packed {
        logic        valid;
        logic        op_ks1;
        logic        op_ks2;
        logic        op_imix;
        logic [3:0]  enc_rcon;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } aes64_req_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Byte 0 of a column sits in the low bits.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
    endfunction
endpackage

module aes64_sbox
    import aes64_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse as a^254 (0 maps to 0), followed by the affine map.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes64
    import aes64_pkg::*;
(
    input  aes64_req_t  req,
    output logic [63:0] result
);
    logic [31:0] rot_w, sub_w, ks1_w, ks2_lo, ks2_hi;
    logic [7:0]  rcon;

    always_comb begin
        case (req.enc_rcon)
            4'h0:    rcon = 8'h01;
            4'h1:    rcon = 8'h02;
            4'h2:    rcon = 8'h04;
            4'h3:    rcon = 8'h08;
            4'h4:    rcon = 8'h10;
            4'h5:    rcon = 8'h20;
            4'h6:    rcon = 8'h40;
            4'h7:    rcon = 8'h80;
            4'h8:    rcon = 8'h1b;
            4'h9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // enc_rcon 0xA is the AES-256 odd step: SubWord without RotWord.
    assign rot_w = (req.enc_rcon == 4'hA) ? req.rs1[63:32]
                                          : {req.rs1[39:32], req.rs1[63:40]};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_sbox
            aes64_sbox u_sbox (.a(rot_w[8*i +: 8]), .y(sub_w[8*i +: 8]));
        end
    endgenerate

    assign ks1_w  = sub_w ^ {24'h0, rcon};
    assign ks2_lo = req.rs1[63:32] ^ req.rs2[31:0];
    assign ks2_hi = ks2_lo ^ req.rs2[63:32];

    always_comb begin
        result = '0;
        if (req.valid) begin
            if (req.op_ks1)       result = {ks1_w, ks1_w};
            else if (req.op_ks2)  result = {ks2_hi, ks2_lo};
            else if (req.op_imix) result = {inv_mix_col(req.rs1[63:32]), inv_mix_col(req.rs1[31:0])};
        end
    end
endmodule

module aes64_ks128_seq
    import aes64_pkg::*;
(
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         key_inv,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, EMIT, KS1, KS2A, KS2B, IMXL, IMXH} state_t;

    state_t       state, state_nxt;
    logic [63:0]  klo, khi, tmp, alu_res;
    logic [127:0] out;
    logic         inv_q;
    logic [3:0]   rnd;
    aes64_req_t   req;

    aes64 u_aes64 (.req(req), .result(alu_res));

    always_ff @(posedge g_clk) begin
        if (g_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req       = '0;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EMIT;
            end
            EMIT: begin
                rk_valid = 1'b1;
                if (rk_ready) state_nxt = (rnd == 4'd10) ? IDLE : KS1;
            end
            KS1: begin
                req.valid    = 1'b1;
                req.op_ks1   = 1'b1;
                req.enc_rcon = rnd - 4'd1;
                req.rs1      = khi;
                state_nxt    = KS2A;
            end
            KS2A: begin
                req.valid  = 1'b1;
                req.op_ks2 = 1'b1;
                req.rs1    = tmp;
                req.rs2    = klo;
                state_nxt  = KS2B;
            end
            KS2B: begin
                req.valid  = 1'b1;
                req.op_ks2 = 1'b1;
                req.rs1    = klo;
                req.rs2    = khi;
                state_nxt  = (inv_q && rnd <= 4'd9) ? IMXL : EMIT;
            end
            IMXL: begin
                req.valid   = 1'b1;
                req.op_imix = 1'b1;
                req.rs1     = klo;
                state_nxt   = IMXH;
            end
            IMXH: begin
                req.valid   = 1'b1;
                req.op_imix = 1'b1;
                req.rs1     = khi;
                state_nxt   = EMIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // klo/khi always hold the raw schedule; imix results only ever land in out.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            klo   <= '0;
            khi   <= '0;
            tmp   <= '0;
            out   <= '0;
            inv_q <= 1'b0;
            rnd   <= '0;
        end else begin
            case (state)
                IDLE: if (key_valid) begin
                    klo   <= key_in[63:0];
                    khi   <= key_in[127:64];
                    out   <= key_in;
                    inv_q <= key_inv;
                    rnd   <= '0;
                end
                EMIT: if (rk_ready && rnd != 4'd10) rnd <= rnd + 4'd1;
                KS1:  tmp <= alu_res;
                KS2A: klo <= alu_res;
                KS2B: begin
                    khi <= alu_res;
                    if (!(inv_q && rnd <= 4'd9)) out <= {alu_res, klo};
                end
                IMXL: out[63:0]   <= alu_res;
                IMXH: out[127:64] <= alu_res;
                default: ;
            endcase
        end
    end

    assign rk_data  = out;
    assign rk_index = rnd;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_aes64_ks128_seq.sv
// Bench for aes64_ks128_seq: directed steps with random keys/backpressure,
// checked against a word-level FIPS-197 key-expansion model.

module tb_aes64_ks128_seq;
    logic         g_clk = 1'b0;
    logic         g_reset = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_inv = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready, rk_valid, busy;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;

    int total = 0;
    int bad = 0;
    int lat10;
    logic [7:0]   sbox_tab [256];
    logic [127:0] m_fwd [11];
    logic [127:0] m_inv [11];
    logic [127:0] got [11];
    logic [127:0] ref_seq [11];

    always #5 g_clk = ~g_clk;

    aes64_ks128_seq dut (
        .g_clk(g_clk), .g_reset(g_reset), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .key_inv(key_inv), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_data(rk_data), .rk_index(rk_index), .busy(busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // FIPS text order (first byte leftmost) to byte-0-in-low-bits packing.
    function automatic logic [127:0] fb(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv, y, c;
        inv = '0;
        c = 8'h63;
        for (int k = 1; k < 256; k++) if (m_mul(x, 8'(k)) == 8'h01) inv = 8'(k);
        for (int i = 0; i < 8; i++)
            y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return y;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  b [4];
        logic [7:0]  t [4];
        logic [7:0]  a [4];
        logic [7:0]  mc [4];
        logic [7:0]  rc, o;
        mc[0] = 8'h0e; mc[1] = 8'h0b; mc[2] = 8'h0d; mc[3] = 8'h09;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            for (int k = 0; k < 4; k++) b[k] = w[i-1][8*k +: 8];
            if (i % 4 == 0) begin
                for (int k = 0; k < 4; k++) t[k] = sbox_tab[b[(k+1)%4]];
                t[0] = t[0] ^ rc;
                rc = m_mul(rc, 8'h02);
            end else begin
                for (int k = 0; k < 4; k++) t[k] = b[k];
            end
            w[i] = w[i-4] ^ {t[3], t[2], t[1], t[0]};
        end
        for (int r = 0; r < 11; r++) begin
            m_fwd[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
            m_inv[r] = m_fwd[r];
        end
        for (int r = 1; r < 10; r++)
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) a[k] = m_fwd[r][32*c + 8*k +: 8];
                for (int k = 0; k < 4; k++) begin
                    o = '0;
                    for (int j = 0; j < 4; j++) o = o ^ m_mul(mc[(j-k+4)%4], a[j]);
                    m_inv[r][32*c + 8*k +: 8] = o;
                end
            end
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge after rk10's handshake.
    task automatic run_key(input logic [127:0] key, input logic inv, input logic rnd_ready, input string tag);
        int n, cyc;
        logic stalled;
        logic [127:0] hold_d;
        logic [3:0] hold_i;
        check({tag, "_accept_ready"}, 128'(key_ready), 128'd1);
        key_valid = 1'b1; key_in = key; key_inv = inv;
        @(negedge g_clk);
        key_valid = 1'b0; key_in = '0; key_inv = 1'b0;
        n = 0; cyc = 1; stalled = 1'b0; lat10 = -1; hold_d = '0; hold_i = '0;
        while (n < 11 && cyc < 1000) begin
            if (stalled) begin
                check({tag, "_stall_valid"}, 128'(rk_valid), 128'd1);
                check({tag, "_stall_data"}, rk_data, hold_d);
                check({tag, "_stall_index"}, 128'(rk_index), 128'(hold_i));
            end
            rk_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rk_valid) begin
                if (rk_index == 4'd10 && lat10 < 0) lat10 = cyc;
                if (rk_ready) begin
                    check($sformatf("%s_index%0d", tag, n), 128'(rk_index), 128'(n));
                    got[n] = rk_data;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d = rk_data;
                    hold_i = rk_index;
                end
            end
            @(negedge g_clk);
            cyc++;
        end
        rk_ready = 1'b0;
        check({tag, "_beats"}, 128'(n), 128'd11);
        check({tag, "_after_ready"}, 128'(key_ready), 128'd1);
        check({tag, "_after_busy"}, 128'(busy), 128'd0);
        check({tag, "_after_valid"}, 128'(rk_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] kf, ka, kb, kr;
        logic ir;
        int acc, acc1, acc2, hs10, quiet;

        for (int x = 0; x < 256; x++) sbox_tab[x] = m_sbox(8'(x));

        repeat (3) @(negedge g_clk);
        check("rst_ready", 128'(key_ready), 128'd1);
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_data", rk_data, 128'd0);
        check("rst_index", 128'(rk_index), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        g_reset = 1'b0;
        repeat (5) begin
            @(negedge g_clk);
            check("idle_ready", 128'(key_ready), 128'd1);
            check("idle_busy", 128'(busy), 128'd0);
            check("idle_valid", 128'(rk_valid), 128'd0);
            check("idle_data", rk_data, 128'd0);
        end

        // FIPS-197 key, forward then inverse.
        kf = fb(128'h2b7e151628aed2a6abf7158809cf4f3c);
        model_expand(kf);
        run_key(kf, 1'b0, 1'b0, "fips_fwd");
        check("fips_fwd_lat", 128'(lat10), 128'd41);
        for (int r = 0; r < 11; r++) check($sformatf("fips_fwd_rk%0d", r), got[r], m_fwd[r]);
        check("fips_rk0_key", got[0], kf);
        check("fips_rk1_const", got[1], fb(128'ha0fafe1788542cb123a339392a6c7605));
        check("fips_rk10_const", got[10], fb(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        for (int r = 0; r < 11; r++) ref_seq[r] = got[r];

        run_key(kf, 1'b1, 1'b0, "fips_inv");
        check("fips_inv_lat", 128'(lat10), 128'd59);
        check("fips_inv_rk0", got[0], ref_seq[0]);
        check("fips_inv_rk10", got[10], ref_seq[10]);
        for (int r = 1; r < 10; r++) check($sformatf("fips_inv_rk%0d", r), got[r], m_inv[r]);

        // Random backpressure must not change the sequence.
        run_key(kf, 1'b0, 1'b1, "bp_fwd");
        for (int r = 0; r < 11; r++) check($sformatf("bp_fwd_rk%0d", r), got[r], ref_seq[r]);
        run_key(kf, 1'b1, 1'b1, "bp_inv");
        for (int r = 0; r < 11; r++) check($sformatf("bp_inv_rk%0d", r), got[r], m_inv[r]);

        model_expand('0);
        run_key('0, 1'b0, 1'b0, "zero");
        check("zero_rk1_const", got[1], fb(128'h62636363626363636263636362636363));
        check("zero_rk10_const", got[10], fb(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
        for (int r = 0; r < 11; r++) check($sformatf("zero_rk%0d", r), got[r], m_fwd[r]);

        repeat (3) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            ir = ($urandom_range(0, 1) == 1);
            model_expand(kr);
            run_key(kr, ir, 1'b1, "rand");
            for (int r = 0; r < 11; r++)
                check($sformatf("rand_inv%0d_rk%0d", ir, r), got[r], ir ? m_inv[r] : m_fwd[r]);
        end

        // key_valid held high: next key only right after the rk10 handshake.
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1; key_in = ka; key_inv = 1'b0; rk_ready = 1'b1;
        acc = 0; acc1 = -1; acc2 = -1; hs10 = -1;
        for (int c = 0; c < 120 && acc < 2; c++) begin
            if (key_ready) begin
                acc++;
                if (acc == 1) acc1 = c; else acc2 = c;
            end else if (rk_valid && rk_index == 4'd10 && hs10 < 0) hs10 = c;
            @(negedge g_clk);
            if (acc == 1) key_in = kb;
        end
        key_valid = 1'b0;
        check("hold_first_accept", 128'(acc1), 128'd0);
        check("hold_rk10_seen", 128'(hs10), 128'd41);
        check("hold_second_accept", 128'(acc2), 128'(hs10 + 1));
        check("hold_rk0_valid", 128'(rk_valid), 128'd1);
        check("hold_rk0_index", 128'(rk_index), 128'd0);
        check("hold_rk0_data", rk_data, kb);

        // Reset while in KS2A abandons the schedule.
        rk_ready = 1'b0;
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        check("rst2_ready", 128'(key_ready), 128'd1);
        key_valid = 1'b1; key_in = ka; rk_ready = 1'b1;
        @(negedge g_clk);
        key_valid = 1'b0;
        check("mid_rk0_valid", 128'(rk_valid), 128'd1);
        repeat (2) @(negedge g_clk);
        check("mid_ks2a_busy", 128'(busy), 128'd1);
        check("mid_ks2a_valid", 128'(rk_valid), 128'd0);
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        check("mid_rst_ready", 128'(key_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_valid", 128'(rk_valid), 128'd0);
        check("mid_rst_data", rk_data, 128'd0);
        check("mid_rst_index", 128'(rk_index), 128'd0);
        quiet = 0;
        repeat (50) begin
            @(negedge g_clk);
            if (rk_valid || busy) quiet++;
        end
        check("mid_rst_quiet", 128'(quiet), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
